// File: rtl/am2950.sv
// am2950 - WIDTH-bit bidirectional I/O port with handshake flags (Am2950 style).
//
// Two independent holding registers:
//   R : loaded from a_i (A side), driven onto b_y (B side) when oebr_ is low.
//   S : loaded from b_i (B side), driven onto a_y (A side) when oeas_ is low.
// Each register has a full flag (fr/fs) and a sticky overrun flag (ovrr/ovrs).
//
// Ports:
//   clk            rising-edge clock
//   rst_           asynchronous active-low reset (clears registers and flags)
//   a_i, b_i       data inputs to R and S
//   cer_, ces_     active-low load enables of R and S
//   clrfr_, clrfs_ active-low synchronous flag clears (acknowledge)
//   oebr_, oeas_   active-low tristate output enables (not gated by reset)
//   b_y, a_y       tristate outputs of R and S
//   fr, fs         full flags
//   ovrr, ovrs     overrun flags
module am2950 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cer_,
  input  logic             ces_,
  input  logic             clrfr_,
  input  logic             clrfs_,
  input  logic             oebr_,
  input  logic             oeas_,
  output logic [WIDTH-1:0] b_y,
  output logic [WIDTH-1:0] a_y,
  output logic             fr,
  output logic             fs,
  output logic             ovrr,
  output logic             ovrs
);

  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] s;

  // R channel. A load wins over a simultaneous clear; in that case the old
  // word counts as consumed, so overrun is cleared rather than set.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r    <= '0;
      fr   <= 1'b0;
      ovrr <= 1'b0;
    end else if (!cer_) begin
      r  <= a_i;
      fr <= 1'b1;
      if (!clrfr_)
        ovrr <= 1'b0;
      else if (fr)
        ovrr <= 1'b1;
    end else if (!clrfr_) begin
      fr   <= 1'b0;
      ovrr <= 1'b0;
    end
  end

  // S channel: same rules as R.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      s    <= '0;
      fs   <= 1'b0;
      ovrs <= 1'b0;
    end else if (!ces_) begin
      s  <= b_i;
      fs <= 1'b1;
      if (!clrfs_)
        ovrs <= 1'b0;
      else if (fs)
        ovrs <= 1'b1;
    end else if (!clrfs_) begin
      fs   <= 1'b0;
      ovrs <= 1'b0;
    end
  end

  assign b_y = oebr_ ? 'z : r;
  assign a_y = oeas_ ? 'z : s;

endmodule
